// File: rtl/pin_regs_pkg.sv
// Register map, command codes and status layout shared by the pin generator and pin sampler blocks.
package pin_regs_pkg;

  localparam logic [20:0] ADDR_GLOBAL_CMD = 21'd0;

  localparam int OFF_PERIOD   = 4;
  localparam int OFF_NSAMPLES = 8;
  localparam int OFF_DATA     = 12;
  localparam int OFF_STATUS   = 16;

  localparam logic [15:0] CMD_START = 16'd1;
  localparam logic [15:0] CMD_STOP  = 16'd2;

  localparam int ST_RUNNING   = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_MSB = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_RUN   = 3'b010,
    S_FLUSH = 3'b100
  } sampler_state_e;

  function automatic logic [20:0] reg_addr(input int position, input int offset);
    return 21'(position + offset);
  endfunction

endpackage

// File: rtl/pin_sampler_if.sv
// Shared addr/data register bus; the host is the master, each pin block is a slave.
interface pin_sampler_if;
  logic [20:0] addr;
  logic [15:0] data_in;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] data_out;

  modport master (output addr, data_in, wr_en, rd_en, input data_out);
  modport slave  (input addr, data_in, wr_en, rd_en, output data_out);
endinterface

// File: rtl/sample_fifo.sv
// Synchronous word FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [15:0]   push_data,
  input  logic          pop,
  output logic [15:0]   pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pin_sampler.sv
// Samples one asynchronous pin every PERIOD ticks, packs samples LSB-first into 16-bit words
// and buffers them for the host, started/stopped by the global command register.
module pin_sampler
  import pin_regs_pkg::*;
#(
  parameter int POSITION   = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  pin_sampler_if.slave  bus,
  input  logic          pin_input,
  output logic          overflow
);

  sampler_state_e state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [15:0] period_q, period_d;
  logic [15:0] nsamples_q, nsamples_d;
  logic [15:0] period_cnt_q, period_cnt_d;
  logic [15:0] samples_left_q, samples_left_d;
  logic        limited_q, limited_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] data_out_q, data_out_d;
  logic        overflow_q, overflow_d;

  logic        start_wr, stop_wr, period_wr, nsamples_wr, data_rd, status_rd;
  logic [15:0] reload, sample_word, push_data, pop_data, status_word;
  logic        push, last_sample, fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_count;

  assign start_wr    = bus.wr_en && bus.addr == ADDR_GLOBAL_CMD && bus.data_in == CMD_START;
  assign stop_wr     = bus.wr_en && bus.addr == ADDR_GLOBAL_CMD && bus.data_in == CMD_STOP;
  assign period_wr   = bus.wr_en && bus.addr == reg_addr(POSITION, OFF_PERIOD);
  assign nsamples_wr = bus.wr_en && bus.addr == reg_addr(POSITION, OFF_NSAMPLES);
  assign data_rd     = bus.rd_en && bus.addr == reg_addr(POSITION, OFF_DATA);
  assign status_rd   = bus.rd_en && bus.addr == reg_addr(POSITION, OFF_STATUS);
  assign reload      = (period_q == '0) ? 16'd1 : period_q;
  assign bus.data_out = data_out_q;
  assign overflow     = overflow_q;

  always_comb begin
    state_d        = state_q;
    period_cnt_d   = period_cnt_q;
    samples_left_d = samples_left_q;
    limited_d      = limited_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    push           = 1'b0;
    push_data      = shift_q;
    last_sample    = 1'b0;
    sample_word    = shift_q;
    sample_word[bit_cnt_q] = sync2_q;
    case (state_q)
      S_IDLE: begin
        if (start_wr) begin
          state_d        = S_RUN;
          period_cnt_d   = reload;
          samples_left_d = nsamples_q;
          limited_d      = (nsamples_q != '0);
          bit_cnt_d      = '0;
        end
      end
      S_RUN: begin
        if (period_cnt_q <= 16'd1) begin
          period_cnt_d = reload;
          bit_cnt_d    = bit_cnt_q + 4'd1;
          // A completed word leaves the shift register clear so a later partial word is zero-padded.
          if (bit_cnt_q == 4'd15) begin
            push      = 1'b1;
            push_data = sample_word;
            shift_d   = '0;
          end else begin
            shift_d   = sample_word;
          end
          if (limited_q) begin
            samples_left_d = samples_left_q - 16'd1;
            last_sample    = (samples_left_q == 16'd1);
          end
        end else begin
          period_cnt_d = period_cnt_q - 16'd1;
        end
        if (last_sample || stop_wr) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        push      = (bit_cnt_q != '0);
        push_data = shift_q;
        bit_cnt_d = '0;
        shift_d   = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    status_word = '0;
    status_word[ST_RUNNING]  = (state_q != S_IDLE);
    status_word[ST_EMPTY]    = fifo_empty;
    status_word[ST_FULL]     = fifo_full;
    status_word[ST_OVERFLOW] = overflow_q;
    status_word[ST_COUNT_MSB:ST_COUNT_LSB] = 5'(fifo_count);

    period_d   = period_wr ? bus.data_in : period_q;
    nsamples_d = nsamples_wr ? bus.data_in : nsamples_q;

    data_out_d = data_out_q;
    if (bus.rd_en) begin
      data_out_d = '0;
      if (data_rd && !fifo_empty) data_out_d = pop_data;
      if (status_rd)              data_out_d = status_word;
    end

    // A full FIFO being popped the same cycle still takes the word, so only then is it a drop.
    if (push && fifo_full && !data_rd) overflow_d = 1'b1;
    else if (status_rd)                overflow_d = 1'b0;
    else                               overflow_d = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      period_q       <= 16'd1;
      nsamples_q     <= '0;
      period_cnt_q   <= '0;
      samples_left_q <= '0;
      limited_q      <= 1'b0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      data_out_q     <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= pin_input;
      sync2_q        <= sync1_q;
      period_q       <= period_d;
      nsamples_q     <= nsamples_d;
      period_cnt_q   <= period_cnt_d;
      samples_left_q <= samples_left_d;
      limited_q      <= limited_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      data_out_q     <= data_out_d;
      overflow_q     <= overflow_d;
    end
  end

  sample_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (data_rd),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_pin_sampler.sv
// Randomized self-checking bench for pin_sampler; expected words come from the sampling rules applied to a recorded pin history.
module tb_pin_sampler;
  import pin_regs_pkg::*;

  localparam logic [20:0] A_PERIOD = 21'd4;
  localparam logic [20:0] A_NSAMP  = 21'd8;
  localparam logic [20:0] A_DATA   = 21'd12;
  localparam logic [20:0] A_STATUS = 21'd16;

  logic clk = 1'b0;
  logic reset;
  logic pin_input;
  logic overflow;

  pin_sampler_if bus();

  pin_sampler #(.POSITION(0), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .pin_input (pin_input),
    .overflow  (overflow)
  );

  always #10 clk = ~clk;

  bit          pin_hist [0:32767];
  int          edge_n   = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] model_words [$];
  logic [15:0] exp_q [$];
  bit          exp_ovf;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change on the falling edge; edge_n names the rising edge that will sample them.
  task automatic nextCycle();
    @(negedge clk);
    edge_n++;
    pin_input  = pin_hist[edge_n];
    bus.wr_en  = 1'b0;
    bus.rd_en  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) nextCycle();
  endtask

  task automatic writeReg(input logic [20:0] a, input logic [15:0] d);
    nextCycle();
    bus.addr    = a;
    bus.data_in = d;
    bus.wr_en   = 1'b1;
  endtask

  task automatic readReg(input logic [20:0] a, output logic [15:0] d);
    nextCycle();
    bus.addr  = a;
    bus.rd_en = 1'b1;
    nextCycle();
    d = bus.data_out;
  endtask

  // Sample k of a run started at edge s lands at edge s+k*peff and sees the pin from two edges earlier.
  function automatic void buildWords(input int s, input int peff, input int n, input int t);
    int k_n;
    int b;
    logic [15:0] w;
    model_words.delete();
    if (t < 0) k_n = n;
    else begin
      k_n = (t - s) / peff;
      if (n > 0 && n < k_n) k_n = n;
    end
    w = '0;
    b = 0;
    for (int k = 1; k <= k_n; k++) begin
      w[b] = pin_hist[s + k*peff - 2];
      b++;
      if (b == 16) begin
        model_words.push_back(w);
        w = '0;
        b = 0;
      end
    end
    if (b > 0) model_words.push_back(w);
  endfunction

  task automatic applyStimulus(input int period, input int nsamp, input int stop_after,
                               input int fill_mode, input logic [15:0] pattern, input int pop_at);
    int peff;
    int s;
    int t;
    int end_e;
    bit popped_valid;
    logic [15:0] popped;
    peff = (period == 0) ? 1 : period;
    s = edge_n + 3;
    if (fill_mode == 1) begin
      for (int i = s - 2; i < s + 4000; i++) pin_hist[i] = 1'b1;
    end else if (fill_mode == 2) begin
      for (int k = 1; k <= 16; k++) pin_hist[s + k*peff - 2] = pattern[k-1];
    end
    writeReg(A_PERIOD, 16'(period));
    writeReg(A_NSAMP, 16'(nsamp));
    writeReg(ADDR_GLOBAL_CMD, CMD_START);
    popped_valid = 0;
    popped = '0;
    if (stop_after > 0) begin
      while (edge_n < s + stop_after - 1) begin
        if (nsamp == 0 && edge_n == s + stop_after/2) writeReg(ADDR_GLOBAL_CMD, CMD_START);
        else nextCycle();
      end
      writeReg(ADDR_GLOBAL_CMD, CMD_STOP);
      t = edge_n;
      waitCycles(3);
    end else begin
      t = -1;
      end_e = s + nsamp*peff + 3;
      while (edge_n < end_e) begin
        if (pop_at > 0 && edge_n + 1 == s + pop_at) begin
          readReg(A_DATA, popped);
          popped_valid = 1;
        end else nextCycle();
      end
    end
    buildWords(s, peff, nsamp, t);
    if (popped_valid) checkOutput("pop on push", popped, model_words.pop_front());
    exp_q.delete();
    exp_ovf = 0;
    foreach (model_words[i]) begin
      if (exp_q.size() < 16) exp_q.push_back(model_words[i]);
      else exp_ovf = 1;
    end
  endtask

  task automatic drainAndCheck(input string tag);
    logic [15:0] d;
    logic [15:0] st;
    st = '0;
    st[1]   = (exp_q.size() == 0);
    st[2]   = (exp_q.size() == 16);
    st[3]   = exp_ovf;
    st[8:4] = 5'(exp_q.size());
    checkOutput({tag, " overflow pin"}, overflow, exp_ovf);
    readReg(A_STATUS, d);
    checkOutput({tag, " status"}, d, st);
    while (exp_q.size() > 0) begin
      readReg(A_DATA, d);
      checkOutput({tag, " word"}, d, exp_q.pop_front());
    end
    readReg(A_DATA, d);
    checkOutput({tag, " empty read"}, d, 16'h0000);
    readReg(A_STATUS, d);
    checkOutput({tag, " status after drain"}, d, 16'h0002);
    checkOutput({tag, " overflow cleared"}, overflow, 1'b0);
  endtask

  initial begin
    logic [15:0] d;
    int p;
    int n;
    int sa;
    for (int i = 0; i < 32768; i++) pin_hist[i] = 1'($urandom);
    reset       = 1'b1;
    pin_input   = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    waitCycles(3);
    reset = 1'b0;
    nextCycle();
    checkOutput("reset data_out", bus.data_out, 16'h0000);
    checkOutput("reset overflow", overflow, 1'b0);
    readReg(A_STATUS, d);
    checkOutput("reset status", d, 16'h0002);
    readReg(21'd20, d);
    checkOutput("unmapped read", d, 16'h0000);
    writeReg(ADDR_GLOBAL_CMD, CMD_STOP);
    waitCycles(4);
    readReg(A_STATUS, d);
    checkOutput("stop in idle", d, 16'h0002);

    $display("[TB] pattern 0xA5C3, PERIOD=4, NSAMPLES=16");
    applyStimulus(4, 16, 0, 2, 16'hA5C3, 0);
    exp_q.delete();
    exp_q.push_back(16'hA5C3);
    drainAndCheck("pattern");

    $display("[TB] PERIOD=1, NSAMPLES=5, pin high");
    applyStimulus(1, 5, 0, 1, 16'h0000, 0);
    exp_q.delete();
    exp_q.push_back(16'h001F);
    drainAndCheck("partial");

    $display("[TB] PERIOD=2, free run, stop after 40");
    applyStimulus(2, 0, 40, 1, 16'h0000, 0);
    exp_q.delete();
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h000F);
    drainAndCheck("stop");

    $display("[TB] FIFO overflow");
    applyStimulus(1, 0, 277, 0, 16'h0000, 0);
    drainAndCheck("overflow");

    $display("[TB] pop on the push cycle of a full FIFO");
    applyStimulus(1, 272, 0, 0, 16'h0000, 272);
    drainAndCheck("full pop");

    $display("[TB] randomized sessions");
    for (int r = 0; r < 8; r++) begin
      p  = $urandom_range(0, 4);
      n  = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 60);
      if (n == 0) sa = $urandom_range(20, 200);
      else sa = ($urandom_range(0, 2) == 0) ? $urandom_range(20, 120) : 0;
      applyStimulus(p, n, sa, 0, 16'h0000, 0);
      drainAndCheck("random");
    end

    $display("[TB] reset mid-run");
    writeReg(A_PERIOD, 16'd1);
    writeReg(A_NSAMP, 16'd0);
    writeReg(ADDR_GLOBAL_CMD, CMD_START);
    waitCycles(40);
    readReg(A_STATUS, d);
    checkOutput("running status", d, 16'h0021);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    checkOutput("reset mid-run data_out", bus.data_out, 16'h0000);
    readReg(A_STATUS, d);
    checkOutput("reset mid-run status", d, 16'h0002);
    waitCycles(40);
    readReg(A_STATUS, d);
    checkOutput("no flush after reset", d, 16'h0002);
    readReg(A_DATA, d);
    checkOutput("no word after reset", d, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
